// File: rtl/result_uart_tx.sv
// result_uart_tx
// Serialises one X/Y/Z result per FINISHED rising edge as a 14-byte 8N1 UART
// frame: SYNC, X, Y and Z as big-endian 32-bit words, then an XOR checksum.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 28,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              EN_i,
    input  logic              FINISHED_i,
    input  logic [DATA_W-1:0] X_i,
    input  logic [DATA_W-1:0] Y_i,
    input  logic [DATA_W-1:0] Z_i,
    output logic              TX_o,
    output logic              BUSY_o,
    output logic              DONE_o,
    output logic              OVERRUN_o
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BYTE = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [7:0]       chk_q, chk_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic [31:0]      z_q, z_d;
    logic             fin_q;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic             rise;
    logic             accept;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign rise    = FINISHED_i & ~fin_q;
    assign accept  = rise & EN_i & (state_q == S_IDLE);
    assign bit_end = (cnt_q == CNT_LAST);

    // Select the frame byte currently on the wire from the latched words.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_q)
            4'd0:    cur_byte = SYNC_BYTE;
            4'd1:    cur_byte = x_q[31:24];
            4'd2:    cur_byte = x_q[23:16];
            4'd3:    cur_byte = x_q[15:8];
            4'd4:    cur_byte = x_q[7:0];
            4'd5:    cur_byte = y_q[31:24];
            4'd6:    cur_byte = y_q[23:16];
            4'd7:    cur_byte = y_q[15:8];
            4'd8:    cur_byte = y_q[7:0];
            4'd9:    cur_byte = z_q[31:24];
            4'd10:   cur_byte = z_q[23:16];
            4'd11:   cur_byte = z_q[15:8];
            4'd12:   cur_byte = z_q[7:0];
            4'd13:   cur_byte = chk_q;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // Next-state logic: capture on accept, then walk START/DATA/STOP per byte.
    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        chk_d     = chk_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (rise & (state_q != S_IDLE));

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    byte_d  = 4'd0;
                    chk_d   = 8'h00;
                    x_d     = 32'(X_i);
                    y_d     = 32'(Y_i);
                    z_d     = 32'(Z_i);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                        byte_d  = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        // Fold the byte just sent into the running checksum.
                        chk_d   = chk_q ^ cur_byte;
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge CLK_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (RST_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 4'd0;
            chk_q     <= 8'h00;
            fin_q     <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            chk_q     <= chk_d;
            fin_q     <= FINISHED_i;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Latched result words.
    always_ff @(posedge CLK_i) begin
        // NOTE: the word registers carry no reset; they are only read in DATA, which is reachable only after an accept loads them.
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
    end

    // Line driver: idle and stop are mark, start is space, data LSB first.
    always_comb begin
        TX_o = 1'b1;
        case (state_q)
            S_START: TX_o = 1'b0;
            S_DATA:  TX_o = cur_byte[bit_q];
            default: TX_o = 1'b1;
        endcase
    end

    assign BUSY_o    = (state_q != S_IDLE);
    assign DONE_o    = done_q;
    assign OVERRUN_o = overrun_q;

endmodule
